bless_inject_ctrl: RTL

Local-port injection scheduler for the two-stage bufferless deflection router. It buffers flits from the processing element (PE) in a small FIFO. It presents the head flit on the router's local input (port 4) only in cycles where a free output slot is guaranteed, so the router's internal injection grant always passes. It also detects injection starvation and raises a throttle request to neighbouring routers.

---
 rtl/bless_inject_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bless_inject_ctrl.sv
// Local-port injection scheduler for the bufferless deflection router: queues PE flits
// and injects the head only when a free output slot is guaranteed, flagging starvation.
module bless_inject_ctrl #(
  parameter int DW           = 64,
  parameter int VLD_POS      = 63,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pe_valid,
  input  logic [DW-1:0]              pe_flit,
  output logic                       pe_ready,
  input  logic [3:0]                 in_vld,
  input  logic [3:0]                 in_eject,
  output logic [DW-1:0]              inj_flit,
  output logic                       starve,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    STARVED = 2'd2
  } state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  state_t        state;
  logic [7:0]    starve_cnt;

  logic          has_eject;
  logic [2:0]    n_in;
  logic          slot_free;
  logic          inject;
  logic          push;
  logic [CW-1:0] count_next;
  logic [7:0]    cnt_inc;

  // Four busy inputs with nobody ejecting is the only case where all four outputs are taken.
  always_comb begin
    has_eject  = |(in_vld & in_eject);
    n_in       = {2'b00, in_vld[0]} + {2'b00, in_vld[1]} +
                 {2'b00, in_vld[2]} + {2'b00, in_vld[3]};
    slot_free  = !((n_in == 3'd4) && !has_eject);
    inject     = (fifo_count != '0) && slot_free;
    push       = pe_valid && pe_ready;
    count_next = fifo_count + CW'(push) - CW'(inject);
    cnt_inc    = (starve_cnt == 8'hFF) ? 8'hFF : starve_cnt + 8'd1;
    inj_flit   = '0;
    if (inject) begin
      inj_flit          = mem[rd_ptr];
      inj_flit[VLD_POS] = 1'b1;
    end
  end

  assign pe_ready = !rst && (fifo_count < CW'(DEPTH));

  // Storage is deliberately left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pe_flit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (inject) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_next;
    end
  end

  // starve is registered alongside the state so it mirrors (state == STARVED) exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          starve_cnt <= '0;
          starve     <= 1'b0;
          if (push) state <= WAIT;
        end
        WAIT: begin
          if (inject) begin
            starve_cnt <= '0;
            state      <= (count_next == '0) ? IDLE : WAIT;
          end else begin
            starve_cnt <= cnt_inc;
            if (cnt_inc >= 8'(STARVE_LIMIT)) begin
              state  <= STARVED;
              starve <= 1'b1;
            end
          end
        end
        STARVED: begin
          if (inject) begin
            starve_cnt <= '0;
            starve     <= 1'b0;
            state      <= (count_next == '0) ? IDLE : WAIT;
          end
        end
        default: begin
          state      <= IDLE;
          starve_cnt <= '0;
          starve     <= 1'b0;
        end
      endcase
    end
  end

endmodule
